// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - shared phase encoding and segment helpers for raster timing
package video_timing_pkg;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FP     = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BP     = 2'd3
    } phase_t;

    function automatic int seg_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/video_timing_gen_axis.sv
// rtl/video_timing_gen_axis.sv - one raster axis: counter plus phase FSM
module timing_axis
    import video_timing_pkg::*;
#(
    parameter int CW     = 10,
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          step,
    output logic [CW-1:0] count,
    output phase_t        phase,
    output logic          wrap
);

    localparam int TOTAL = seg_total(ACTIVE, FP, SYNC, BP);
    localparam logic [CW-1:0] END_ACTIVE = CW'(ACTIVE - 1);
    localparam logic [CW-1:0] END_FP     = CW'(ACTIVE + FP - 1);
    localparam logic [CW-1:0] END_SYNC   = CW'(ACTIVE + FP + SYNC - 1);
    localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);

    logic [CW-1:0] count_next;
    phase_t        phase_next;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
            phase <= PH_ACTIVE;
        end else begin
            count <= count_next;
            phase <= phase_next;
        end
    end

    // Phase is registered from the next count, so it lines up with count on the same edge.
    always_comb begin
        count_next = count;
        phase_next = phase;
        if (step) begin
            count_next = wrap ? '0 : count + 1'b1;
            unique case (phase)
                PH_ACTIVE: if (count == END_ACTIVE) phase_next = PH_FP;
                PH_FP:     if (count == END_FP)     phase_next = PH_SYNC;
                PH_SYNC:   if (count == END_SYNC)   phase_next = PH_BP;
                PH_BP:     if (count == LAST)       phase_next = PH_ACTIVE;
            endcase
        end
    end

    always_comb begin
        wrap = step && (count == LAST);
    end

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - horizontal/vertical raster timing generator
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int CW       = 10,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic          restart,
    output logic [CW-1:0] hcount,
    output logic [CW-1:0] vcount,
    output logic          hsync,
    output logic          vsync,
    output logic          active,
    output logic          hblank,
    output logic          vblank,
    output logic          line_tick,
    output logic          frame_tick
);

    localparam int H_TOTAL = seg_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = seg_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        H_TOTAL > 2**CW || V_TOTAL > 2**CW) begin : g_param_check
        $error("video_timing_gen: invalid timing parameters");
    end

    phase_t h_phase;
    phase_t v_phase;
    logic   h_wrap;
    logic   v_wrap;

    timing_axis #(
        .CW(CW), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
    ) u_h_axis (
        .clk(clk), .rst(rst), .clear(restart), .step(ce),
        .count(hcount), .phase(h_phase), .wrap(h_wrap)
    );

    // Vertical axis advances once per horizontal wrap.
    timing_axis #(
        .CW(CW), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
    ) u_v_axis (
        .clk(clk), .rst(rst), .clear(restart), .step(ce & h_wrap),
        .count(vcount), .phase(v_phase), .wrap(v_wrap)
    );

    always_comb begin
        hsync  = (h_phase == PH_SYNC) ? H_POL : ~H_POL;
        vsync  = (v_phase == PH_SYNC) ? V_POL : ~V_POL;
        hblank = (h_phase != PH_ACTIVE);
        vblank = (v_phase != PH_ACTIVE);
        active = ~hblank & ~vblank;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_tick  <= 1'b0;
            frame_tick <= 1'b0;
        end else if (restart) begin
            line_tick  <= 1'b1;
            frame_tick <= 1'b1;
        end else begin
            line_tick  <= h_wrap;
            frame_tick <= h_wrap & v_wrap;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - self-checking bench for video_timing_gen
module tb_video_timing_gen;

    localparam int HA = 4, HF = 1, HS = 2, HB = 1;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int HT = 8, VT = 6;
    localparam int SCW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, restart = 1'b0, ce = 1'b0;
    logic [SCW-1:0] hcount, vcount;
    logic hsync, vsync, active, hblank, vblank, line_tick, frame_tick;

    video_timing_gen #(
        .CW(SCW), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .H_POL(1'b0), .V_POL(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .ce(ce), .restart(restart),
        .hcount(hcount), .vcount(vcount), .hsync(hsync), .vsync(vsync),
        .active(active), .hblank(hblank), .vblank(vblank),
        .line_tick(line_tick), .frame_tick(frame_tick)
    );

    logic b_rst = 1'b1, b_restart = 1'b0, b_ce = 1'b0;
    logic [9:0] b_hcount, b_vcount;
    logic b_hsync, b_vsync, b_active, b_hblank, b_vblank, b_line_tick, b_frame_tick;

    video_timing_gen dut_big (
        .clk(clk), .rst(b_rst), .ce(b_ce), .restart(b_restart),
        .hcount(b_hcount), .vcount(b_vcount), .hsync(b_hsync), .vsync(b_vsync),
        .active(b_active), .hblank(b_hblank), .vblank(b_vblank),
        .line_tick(b_line_tick), .frame_tick(b_frame_tick)
    );

    int n_pass = 0;
    int n_total = 0;

    // Reference position and tick state, updated from the raster rules.
    int mh = 0, mv = 0;
    bit mlt = 0, mft = 0;

    typedef struct {
        bit r, rs, c;
        int hc, vc;
        bit lt, ft;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic model_step(input bit r, input bit rs, input bit c);
        if (r) begin
            mh = 0; mv = 0; mlt = 0; mft = 0;
        end else if (rs) begin
            mh = 0; mv = 0; mlt = 1; mft = 1;
        end else if (c) begin
            mlt = (mh == HT - 1);
            mft = mlt && (mv == VT - 1);
            mh = (mh + 1) % HT;
            if (mlt) mv = (mv + 1) % VT;
        end else begin
            mlt = 0; mft = 0;
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".hcount"}, int'(hcount), mh);
        check({tag, ".vcount"}, int'(vcount), mv);
        check({tag, ".hsync"}, int'(hsync), (mh >= HA + HF && mh < HA + HF + HS) ? 0 : 1);
        check({tag, ".vsync"}, int'(vsync), (mv >= VA + VF && mv < VA + VF + VS) ? 0 : 1);
        check({tag, ".active"}, int'(active), (mh < HA && mv < VA) ? 1 : 0);
        check({tag, ".hblank"}, int'(hblank), (mh >= HA) ? 1 : 0);
        check({tag, ".vblank"}, int'(vblank), (mv >= VA) ? 1 : 0);
        check({tag, ".line_tick"}, int'(line_tick), int'(mlt));
        check({tag, ".frame_tick"}, int'(frame_tick), int'(mft));
    endtask

    task automatic drive(input bit r, input bit rs, input bit c);
        rst = r; restart = rs; ce = c;
        @(posedge clk);
        #1;
        model_step(r, rs, c);
    endtask

    function automatic vec_t mk(input bit r, input bit rs, input bit c,
                                input int hc, input int vc, input bit lt, input bit ft);
        vec_t v;
        v.r = r; v.rs = rs; v.c = c; v.hc = hc; v.vc = vc; v.lt = lt; v.ft = ft;
        return v;
    endfunction

    initial begin
        int act_cnt, hs_low, vs_low, vs_bad, lt_cnt, ft_cnt, ft_at;
        int b_low, b_first, b_lt_at;

        // Directed vectors: reset, one full line, ce gaps, restart, rst over restart.
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0));
        for (int i = 1; i < 8; i++) vecs.push_back(mk(0, 0, 1, i, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].r, vecs[i].rs, vecs[i].c);
            check($sformatf("vec%0d.hcount", i), int'(hcount), vecs[i].hc);
            check($sformatf("vec%0d.vcount", i), int'(vcount), vecs[i].vc);
            check($sformatf("vec%0d.line_tick", i), int'(line_tick), int'(vecs[i].lt));
            check($sformatf("vec%0d.frame_tick", i), int'(frame_tick), int'(vecs[i].ft));
            check_model($sformatf("vec%0d", i));
        end

        // One full frame of continuous ce.
        drive(1, 0, 0);
        check_model("frame.reset");
        act_cnt = 0; hs_low = 0; vs_low = 0; vs_bad = 0; lt_cnt = 0; ft_cnt = 0; ft_at = -1;
        for (int i = 1; i <= 48; i++) begin
            drive(0, 0, 1);
            if (active) act_cnt++;
            if (!hsync) hs_low++;
            if (!vsync) vs_low++;
            if ((!vsync) != (vcount == 3'd4)) vs_bad++;
            if (line_tick) lt_cnt++;
            if (frame_tick) begin ft_cnt++; ft_at = i; end
        end
        check("frame.active_clks", act_cnt, 12);
        check("frame.hsync_low_clks", hs_low, 12);
        check("frame.vsync_low_clks", vs_low, 8);
        check("frame.vsync_outside_line4", vs_bad, 0);
        check("frame.line_ticks", lt_cnt, 6);
        check("frame.frame_ticks", ft_cnt, 1);
        check("frame.frame_tick_clk", ft_at, 48);
        check_model("frame.end");

        // Restart in the middle of both sync pulses.
        drive(1, 0, 0);
        for (int i = 0; i < 37; i++) drive(0, 0, 1);
        check("midsync.hcount", int'(hcount), 5);
        check("midsync.vcount", int'(vcount), 4);
        check("midsync.hsync", int'(hsync), 0);
        check("midsync.vsync", int'(vsync), 0);
        drive(0, 1, 0);
        check("restart.hcount", int'(hcount), 0);
        check("restart.vcount", int'(vcount), 0);
        check("restart.hsync", int'(hsync), 1);
        check("restart.vsync", int'(vsync), 1);
        check("restart.active", int'(active), 1);
        check("restart.line_tick", int'(line_tick), 1);
        check("restart.frame_tick", int'(frame_tick), 1);
        drive(0, 0, 0);
        check("restart.tick_drop", int'(line_tick | frame_tick), 0);
        check_model("restart.hold");

        // rst mid-frame.
        for (int i = 0; i < 20; i++) drive(0, 0, 1);
        drive(1, 0, 1);
        check("rst_mid.hcount", int'(hcount), 0);
        check("rst_mid.vcount", int'(vcount), 0);
        check_model("rst_mid");

        // Randomised traffic against the reference.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 59) == 0, $urandom_range(0, 9) < 7);
            check_model("rand");
        end
        drive(0, 0, 0);

        // Default 640x480 timing: one full line.
        @(posedge clk); #1;
        b_rst = 1'b0; b_ce = 1'b1;
        b_low = 0; b_first = -1; b_lt_at = -1;
        for (int i = 1; i <= 800; i++) begin
            @(posedge clk); #1;
            if (!b_hsync) begin
                if (b_first < 0) b_first = int'(b_hcount);
                b_low++;
            end
            if (b_line_tick && b_lt_at < 0) b_lt_at = i;
        end
        check("vga.hsync_low_clks", b_low, 96);
        check("vga.hsync_start", b_first, 656);
        check("vga.line_period", b_lt_at, 800);
        check("vga.hcount_wrap", int'(b_hcount), 0);
        check("vga.vcount_step", int'(b_vcount), 1);
        check("vga.frame_tick", int'(b_frame_tick), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
